perf_exit_monitor: RTL and testbench

//  Memory-mapped simulation-control and performance-monitor peripheral on the dmem bus.

---
 rtl/perf_exit_monitor_pkg.sv | 19 +
 rtl/perf_exit_monitor_counter.sv | 30 +++
 rtl/perf_exit_monitor.sv | 183 ++++++++++++++++++
 tb/tb_perf_exit_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_exit_monitor_pkg.sv
// Shared register map, STATUS bit positions and types for the performance/exit monitor.
package pkg_perfmon;

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_EXIT     = 8'h04;
  localparam logic [7:0] OFS_STATUS   = 8'h08;
  localparam logic [7:0] OFS_CYCLE_LO = 8'h10;
  localparam logic [7:0] OFS_CYCLE_HI = 8'h14;
  localparam logic [7:0] OFS_EVT_BASE = 8'h20;

  localparam int STATUS_EXIT_BIT    = 0;
  localparam int STATUS_OVF_BASE    = 1;
  localparam int STATUS_CYC_OVF_BIT = 17;

  typedef enum logic {IDLE, RESP} perf_state_e;

  typedef logic [63:0] cnt_t;

endpackage

// File: rtl/perf_exit_monitor_counter.sv
// Free-running counter with enable, increment strobe and priority clear.
// ovf_o flags the cycle in which an increment wraps the counter back to zero.
module perf_counter #(
  parameter int CntWidth = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                en_i,
  input  logic                clr_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                ovf_o
);

  logic [CntWidth-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (en_i && inc_i) begin
      cnt_reg <= cnt_reg + CntWidth'(1);
    end
  end

  assign cnt_o = cnt_reg;
  assign ovf_o = en_i & inc_i & ~clr_i & (&cnt_reg);

endmodule

// File: rtl/perf_exit_monitor.sv
// Simulation-control / performance-monitor peripheral: cycle and event counters,
// sticky exit flag with code, atomic 64-bit reads through a LO-captured shadow.
module perf_exit_monitor
  import pkg_perfmon::*;
#(
  parameter int                DWidth       = 32,
  parameter logic [DWidth-1:0] BaseAddr     = 32'h0200_0000,
  parameter int                NumCh        = 4,
  parameter int                CntWidth     = 64,
  parameter bit                FreezeOnExit = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  output logic              ready_o,
  output logic [DWidth-1:0] rdata_o,
  output logic              sel_o,
  input  logic [NumCh-1:0]  event_i,
  output logic              exit_o,
  output logic [DWidth-1:0] exit_code_o
);

  perf_state_e       state_reg, state_next;
  logic [DWidth-1:0] rel_addr, exit_code_reg, rdata_reg, rd_value;
  logic [7:0]        offset;
  logic [4:0]        evt_k, cnt_id, tag_id_reg;
  logic [31:0]       shadow_reg, status_word;
  logic [NumCh-1:0]  ovf_evt_reg, evt_wrap;
  logic              access, enable_reg, clr_reg, exit_reg, count_en;
  logic              ovf_cyc_reg, cyc_wrap, tag_valid_reg;
  logic              cnt_hit, is_hi, tag_match;
  logic              wr_ctrl, wr_exit, wr_status;
  logic [CntWidth-1:0] cycle_cnt;
  cnt_t              cnt_all [NumCh+1];
  cnt_t              cnt_sel;

  // Window decode; id 0 is the cycle counter, id 1+k is event channel k.
  assign rel_addr = addr_i - BaseAddr;
  assign sel_o    = (rel_addr < DWidth'(256));
  assign offset   = rel_addr[7:0];
  assign evt_k    = offset[7:3] - 5'd4;
  assign is_hi    = offset[2];
  assign access   = (state_reg == IDLE) & req_i & sel_o;

  always_comb begin
    cnt_hit = 1'b0;
    cnt_id  = '0;
    if (offset[1:0] == 2'b00) begin
      if (offset[7:3] == OFS_CYCLE_LO[7:3]) begin
        cnt_hit = 1'b1;
      end else if (offset >= OFS_EVT_BASE && evt_k < 5'(NumCh)) begin
        cnt_hit = 1'b1;
        cnt_id  = evt_k + 5'd1;
      end
    end
  end

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i <= NumCh; i++) begin
      if (cnt_id == 5'(i)) cnt_sel = cnt_all[i];
    end
  end

  assign tag_match = tag_valid_reg && (tag_id_reg == cnt_id);

  always_comb begin
    status_word                     = '0;
    status_word[STATUS_EXIT_BIT]    = exit_reg;
    status_word[STATUS_CYC_OVF_BIT] = ovf_cyc_reg;
    for (int k = 0; k < NumCh; k++) status_word[STATUS_OVF_BASE+k] = ovf_evt_reg[k];
  end

  always_comb begin
    rd_value = '0;
    if (cnt_hit) begin
      if (is_hi) rd_value = DWidth'(tag_match ? shadow_reg : cnt_sel[63:32]);
      else       rd_value = DWidth'(cnt_sel[31:0]);
    end else begin
      case (offset)
        OFS_CTRL:   rd_value = DWidth'(enable_reg);
        OFS_EXIT:   rd_value = exit_code_reg;
        OFS_STATUS: rd_value = DWidth'(status_word);
        default:    rd_value = '0;
      endcase
    end
  end

  assign wr_ctrl   = access & write_i & (offset == OFS_CTRL);
  assign wr_exit   = access & write_i & (offset == OFS_EXIT);
  assign wr_status = access & write_i & (offset == OFS_STATUS);

  // Clear is a one-cycle pulse issued the cycle after the CTRL write; overflow set beats W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_reg     <= '0;
      enable_reg    <= 1'b0;
      clr_reg       <= 1'b0;
      exit_reg      <= 1'b0;
      exit_code_reg <= '0;
      ovf_evt_reg   <= '0;
      ovf_cyc_reg   <= 1'b0;
      shadow_reg    <= '0;
      tag_valid_reg <= 1'b0;
      tag_id_reg    <= '0;
    end else begin
      clr_reg <= wr_ctrl & wdata_i[1];
      if (wr_ctrl) enable_reg <= wdata_i[0];
      if (wr_exit) begin
        exit_reg      <= 1'b1;
        exit_code_reg <= wdata_i;
      end
      if (access) rdata_reg <= write_i ? '0 : rd_value;
      if (access && !write_i && cnt_hit) begin
        if (!is_hi) begin
          shadow_reg    <= cnt_sel[63:32];
          tag_valid_reg <= 1'b1;
          tag_id_reg    <= cnt_id;
        end else if (tag_match) begin
          tag_valid_reg <= 1'b0;
        end
      end
      for (int k = 0; k < NumCh; k++) begin
        ovf_evt_reg[k] <= (ovf_evt_reg[k] & ~(wr_status & wdata_i[STATUS_OVF_BASE+k])) | evt_wrap[k];
      end
      ovf_cyc_reg <= (ovf_cyc_reg & ~(wr_status & wdata_i[STATUS_CYC_OVF_BIT])) | cyc_wrap;
    end
  end

  assign count_en    = enable_reg & ~(FreezeOnExit & exit_reg);
  assign exit_o      = exit_reg;
  assign exit_code_o = exit_code_reg;

  perf_counter #(.CntWidth(CntWidth)) u_cycle (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (1'b1),
    .en_i   (count_en),
    .clr_i  (clr_reg),
    .cnt_o  (cycle_cnt),
    .ovf_o  (cyc_wrap)
  );
  assign cnt_all[0] = cnt_t'(cycle_cnt);

  generate
    for (genvar gi = 0; gi < NumCh; gi++) begin : gen_evt
      logic [CntWidth-1:0] evt_cnt;
      perf_counter #(.CntWidth(CntWidth)) u_evt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (event_i[gi]),
        .en_i   (count_en),
        .clr_i  (clr_reg),
        .cnt_o  (evt_cnt),
        .ovf_o  (evt_wrap[gi])
      );
      assign cnt_all[gi+1] = cnt_t'(evt_cnt);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_i && sel_o) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_reg == RESP);
    rdata_o = ready_o ? rdata_reg : '0;
  end

endmodule

// File: tb/tb_perf_exit_monitor.sv
// Randomised bench for perf_exit_monitor against a register-level reference model.
module tb_perf_exit_monitor;

  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        sel_o;
  logic [NCH-1:0] event_i = '0;
  logic        exit_o;
  logic [31:0] exit_code_o;

  perf_exit_monitor dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .write_i     (write_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ready_o     (ready_o),
    .rdata_o     (rdata_o),
    .sel_o       (sel_o),
    .event_i     (event_i),
    .exit_o      (exit_o),
    .exit_code_o (exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_ev  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    logic [31:0] r;
    r = a - BASE;
    return r < 32'd256;
  endfunction

  // Reference model: index 0 = cycle counter, 1+k = event channel k.
  logic [63:0] m_cnt [NCH+1];
  bit          m_ovf [NCH+1];
  bit          m_en, m_clr_pend, m_exit, m_resp, m_tag_v;
  int          m_tag;
  logic [31:0] m_code, m_rdata, m_shadow;

  always @(posedge clk_i or negedge rst_ni) begin : model
    bit          run, clr_now, is_cnt, is_hi;
    int          c;
    logic [31:0] off, val;
    if (!rst_ni) begin
      for (int i = 0; i <= NCH; i++) begin
        m_cnt[i] = '0;
        m_ovf[i] = 1'b0;
      end
      m_en = 0; m_clr_pend = 0; m_exit = 0; m_resp = 0; m_tag_v = 0; m_tag = 0;
      m_code = '0; m_rdata = '0; m_shadow = '0;
    end else begin
      run        = m_en && !m_exit;
      clr_now    = m_clr_pend;
      m_clr_pend = 1'b0;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (req_i && in_window(addr_i)) begin
        off    = addr_i - BASE;
        is_cnt = 1'b0; is_hi = 1'b0; c = 0; val = '0;
        if (off == 32'h10 || off == 32'h14) begin
          is_cnt = 1'b1; c = 0; is_hi = (off == 32'h14);
        end else if (off >= 32'h20 && off < 32'h20 + 8 * NCH && off % 4 == 0) begin
          is_cnt = 1'b1; c = 1 + int'((off - 32'h20) / 8); is_hi = ((off % 8) == 4);
        end
        if (!write_i) begin
          if (off == 32'h0) val = {31'b0, m_en};
          else if (off == 32'h4) val = m_code;
          else if (off == 32'h8) begin
            val[0] = m_exit;
            for (int i = 0; i < NCH; i++) val[1+i] = m_ovf[1+i];
            val[17] = m_ovf[0];
          end else if (is_cnt && !is_hi) begin
            val = m_cnt[c][31:0]; m_shadow = m_cnt[c][63:32]; m_tag_v = 1'b1; m_tag = c;
          end else if (is_cnt) begin
            if (m_tag_v && m_tag == c) begin
              val = m_shadow; m_tag_v = 1'b0;
            end else begin
              val = m_cnt[c][63:32];
            end
          end
        end else begin
          if (off == 32'h0) begin
            m_en = wdata_i[0]; m_clr_pend = wdata_i[1];
          end else if (off == 32'h4) begin
            m_exit = 1'b1; m_code = wdata_i;
          end else if (off == 32'h8) begin
            if (wdata_i[17]) m_ovf[0] = 1'b0;
            for (int i = 0; i < NCH; i++) if (wdata_i[1+i]) m_ovf[1+i] = 1'b0;
          end
        end
        m_rdata = val;
        m_resp  = 1'b1;
      end
      for (int i = 0; i <= NCH; i++) begin
        if (clr_now) m_cnt[i] = '0;
        else if (run && (i == 0 || event_i[i-1])) begin
          if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf[i] = 1'b1;
          m_cnt[i] = m_cnt[i] + 64'd1;
        end
      end
    end
  end

  // Per-cycle comparison of all bus-visible outputs.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      check("ready", ready_o, m_resp);
      check("rdata", rdata_o, m_resp ? m_rdata : 32'h0);
      check("exit", exit_o, m_exit);
      check("exit_code", exit_code_o, m_code);
    end
  end

  task automatic tick();
    @(negedge clk_i);
    if (rnd_ev) event_i = NCH'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int waited;
    bit hit;
    tick();
    req_i = 1'b1; write_i = wr; addr_i = addr; wdata_i = wd;
    hit = in_window(addr);
    #1 check("sel", sel_o, hit);
    rd = '0;
    if (!hit) begin
      tick();
      tick();
    end else begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (ready_o !== 1'b1 && waited < 4);
      check("latency", waited, 1);
      rd = rdata_o;
    end
    req_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic pulse(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      event_i = '0; event_i[ch] = 1'b1;
      tick();
      event_i = '0;
      tick();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim
    logic [31:0] rd, a, b, addr;
    int k;
    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ready", ready_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_exit", exit_o, 1'b0);
    check("rst_code", exit_code_o, 32'h0);
    rst_ni = 1'b1;

    // 1: cycle counter off, then on for ~100 cycles
    bus(0, BASE + 32'h10, 0, rd);
    check("cycle_lo_rst", rd, 32'h0);
    bus(1, BASE + 32'h00, 32'h1, rd);
    idle(99);
    bus(0, BASE + 32'h10, 0, rd);
    check("cycle_100", (rd >= 98 && rd <= 102), 1'b1);

    // 2: event channel 2
    pulse(2, 7);
    bus(0, BASE + 32'h30, 0, rd);
    check("evt2_lo", rd, 32'd7);
    bus(0, BASE + 32'h20, 0, rd);
    check("evt0_lo", rd, 32'd0);
    bus(0, BASE + 32'h30, 0, rd);
    bus(0, BASE + 32'h34, 0, rd);
    check("evt2_hi", rd, 32'd0);

    // 3: atomic 64-bit read across a 32-bit carry
    tick();
    force dut.gen_evt[1].u_evt.cnt_reg = 64'h0000_0000_FFFF_FFFF;
    m_cnt[2] = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.gen_evt[1].u_evt.cnt_reg;
    bus(0, BASE + 32'h28, 0, rd);
    check("evt1_lo_max", rd, 32'hFFFF_FFFF);
    event_i = 4'b0010;
    idle(5);
    event_i = '0;
    bus(0, BASE + 32'h2C, 0, rd);
    check("evt1_hi_shadow", rd, 32'd0);
    bus(0, BASE + 32'h2C, 0, rd);
    check("evt1_hi_live", rd, 32'd1);

    // Full 64-bit wrap on channel 3, then W1C of its overflow bit
    tick();
    force dut.gen_evt[3].u_evt.cnt_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.gen_evt[3].u_evt.cnt_reg;
    pulse(3, 1);
    bus(0, BASE + 32'h38, 0, rd);
    check("evt3_wrap_lo", rd, 32'd0);
    bus(0, BASE + 32'h08, 0, rd);
    check("status_ovf3", rd[4], 1'b1);
    bus(1, BASE + 32'h08, 32'h0000_0010, rd);
    bus(0, BASE + 32'h08, 0, rd);
    check("status_w1c", rd[4], 1'b0);

    // 4: clear together with an event, enable kept
    event_i = 4'b0001;
    bus(1, BASE + 32'h00, 32'h3, rd);
    tick();
    event_i = '0;
    bus(0, BASE + 32'h20, 0, rd);
    check("evt0_cleared", rd, 32'd0);
    bus(0, BASE + 32'h00, 0, rd);
    check("ctrl_after_clr", rd, 32'd1);

    // Randomised traffic with random events
    rnd_ev = 1'b1;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 7))
        0: bus(1, BASE, {30'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0)}, rd);
        1: bus(0, BASE, 0, rd);
        2: bus(0, BASE + 32'h08, 0, rd);
        3: bus(1, BASE + 32'h08, $urandom, rd);
        4, 5: begin
          k = $urandom_range(0, NCH + 1);
          addr = (k == NCH + 1) ? BASE + 32'h10 : BASE + 32'h20 + 32'(8 * k);
          bus(0, addr, 0, rd);
          idle($urandom_range(0, 3));
          bus(0, addr + 32'h4, 0, rd);
        end
        6: bus(0, BASE + 32'h04, 0, rd);
        default: begin
          if ($urandom_range(0, 1) == 1) addr = BASE + 32'($urandom_range(0, 63) * 4);
          else addr = BASE + 32'h100 + 32'($urandom_range(0, 3) * 4);
          bus($urandom_range(0, 1) == 1, addr, $urandom, rd);
        end
      endcase
      idle($urandom_range(0, 2));
    end
    rnd_ev = 1'b0;
    event_i = '0;

    // 5: exit freezes counters
    bus(1, BASE, 32'h1, rd);
    bus(1, BASE + 32'h04, 32'h0009_9999, rd);
    tick();
    check("exit_set", exit_o, 1'b1);
    check("exit_code_set", exit_code_o, 32'h0009_9999);
    bus(0, BASE + 32'h08, 0, rd);
    check("status_exit", rd[0], 1'b1);
    bus(0, BASE + 32'h10, 0, a);
    idle(50);
    bus(0, BASE + 32'h10, 0, b);
    check("cycle_frozen", b, a);
    bus(1, BASE + 32'h04, 32'h0000_0123, rd);
    tick();
    check("exit_rewrite", exit_code_o, 32'h0000_0123);

    // 6: unmapped offset, then reset during a response
    bus(0, BASE + 32'hFC, 0, rd);
    check("unmapped_rd", rd, 32'h0);
    tick();
    req_i = 1'b1; write_i = 1'b0; addr_i = BASE + 32'h04;
    tick();
    check("resp_before_rst", ready_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_ready", ready_o, 1'b0);
    check("rst_mid_rdata", rdata_o, 32'h0);
    check("rst_mid_exit", exit_o, 1'b0);
    check("rst_mid_code", exit_code_o, 32'h0);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus(0, BASE + 32'h00, 0, rd);
    check("post_rst_ctrl", rd, 32'h0);
    bus(0, BASE + 32'h08, 0, rd);
    check("post_rst_status", rd, 32'h0);
    bus(0, BASE + 32'h10, 0, rd);
    check("post_rst_cycle", rd, 32'h0);
    bus(0, BASE + 32'h2C, 0, rd);
    check("post_rst_evt1_hi", rd, 32'h0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
